multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width and SHALL be at least 4.
REQ-002 The block SHALL have parameter MUL_EN, default 1, which enables the multi-cycle MUL operation when set to 1.

Interface
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst  input  1  Reset; synchronous and active-high.
REQ-005 in_valid  input  1  Operand/opcode present.
REQ-006 in_ready  output  1  Block can accept an operation this cycle.
REQ-007 a_in  input  WIDTH  Operand A.
REQ-008 b_in  input  WIDTH  Operand B, or shift amount in its low $clog2(WIDTH) bits.
REQ-009 alu_control  input  4  Opcode.
REQ-010 out_valid  output  1  Result and flags valid.
REQ-011 out_ready  input  1  Consumer takes the result.
REQ-012 alu_result  output  WIDTH  Registered result.
REQ-013 zero, negative, carry, overflow  output  1 each  Registered flags.
REQ-014 busy  output  1  High while a MUL is iterating.

Function
REQ-015 Opcodes SHALL be encoded as follows:
- 0 AND, 1 ORR, 2 ADD, 3 SUB, 4 PASS (result = b_in), 5 NOR
- 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 SLT (signed A<B gives 1, else 0), 11 MUL
- 12-15: a_in & b_in
REQ-016 An operation SHALL be accepted only on a cycle where in_valid && in_ready.
REQ-017 Operands and opcode SHALL be captured on accept; later input changes SHALL have no effect.
REQ-018 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-019 The FSM SHALL have states IDLE and MUL:
- IDLE -> MUL on accepting opcode 11 with MUL_EN=1
- MUL -> IDLE after WIDTH iterations
- All other accepts stay in IDLE
REQ-020 Non-MUL ops SHALL be registered with 1-cycle latency:
- Accepted at edge N, result and out_valid=1 present after edge N+1.
- Back-to-back accepts SHALL sustain 1 op/cycle while out_ready=1.
REQ-021 MUL SHALL be a shift-add multiplier doing one iteration per cycle, with busy=1 for exactly WIDTH cycles.
REQ-022 MUL SHALL assert out_valid on the cycle after the last iteration, with alu_result = low WIDTH bits of the unsigned product.
REQ-023 With MUL_EN=0, opcode 11 SHALL behave as the default (AND) with 1-cycle latency.
REQ-024 While out_valid && !out_ready, alu_result, all flags and out_valid SHALL hold unchanged and no new operation SHALL be accepted.
REQ-025 out_valid SHALL clear on the cycle after out_valid && out_ready unless a new result is loaded on that same edge.
REQ-026 zero SHALL equal (alu_result==0) and negative SHALL equal alu_result[WIDTH-1], for every opcode.
REQ-027 For ADD, carry SHALL be the unsigned carry-out, and overflow SHALL be set when the operands have equal signs and the result sign differs.
REQ-028 For SUB, carry SHALL be 1 when a_in >= b_in (unsigned, no borrow), and overflow SHALL be set when the operand signs differ and the result sign differs from a_in.
REQ-029 For all other opcodes, carry and overflow SHALL be 0.
REQ-030 Shifts SHALL use only b_in[$clog2(WIDTH)-1:0]; SRA SHALL sign-extend and SLL/SRL SHALL zero-fill.
REQ-031 All arithmetic SHALL wrap modulo 2^WIDTH, with no saturation.

Reset
REQ-032 When rst=1 at a clock edge:
- state = IDLE
- out_valid, busy, alu_result and all four flags = 0
- any in-progress MUL is discarded with no output produced
REQ-033 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-034 rst SHALL take priority over every accept or handshake on the same edge.

Verification
REQ-035 Bench (WIDTH=32, MUL_EN=1) SHALL cover these directed scenarios:
- ADD a=0xFFFFFFFF, b=1 -> next cycle: result 0, zero=1, carry=1, overflow=0, out_valid=1.
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, negative=1, overflow=1, carry=0.
- SUB a=3, b=5 -> result 0xFFFFFFFE, carry=0, negative=1. SLT with the same operands -> result 1.
- SRA a=0x80000000, b=0x24 (amount 4) -> result 0xF8000000. SLL a=1, b=31 -> result 0x80000000.
- MUL a=12345, b=678 -> busy high 32 cycles, in_ready=0 throughout, then result 8369910.
- MUL a=0xFFFFFFFF, b=2 -> result 0xFFFFFFFE.
- rst asserted at MUL iteration 10 -> next cycle busy=0, out_valid=0, in_ready=1.
- out_ready held 0 for 5 cycles after an ADD -> result stable, in_ready=0.
- Then out_ready=1 with a queued op -> new result on the next cycle, no op lost or duplicated.
- Streaming 100 random non-MUL ops with out_ready=1 -> one result per cycle, matching the reference model.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus an iterative
// shift-add multiplier, with valid/ready handshakes on both sides.
module multicycle_alu #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             is_mul;
  logic             last_it;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;
  logic [SW-1:0]    shamt;

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (alu_control == 4'd11);
  assign last_it  = (cnt_q == SW'(WIDTH - 1));
  assign acc_nx   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign shamt    = b_in[SW-1:0];

  assign busy       = (state_q == MUL);
  assign out_valid  = ov_q;
  assign alu_result = res_q;
  assign zero       = z_q;
  assign negative   = n_q;
  assign carry      = c_q;
  assign overflow   = v_q;

  // SUB as a + ~b + 1 so the carry-out is the "no borrow" flag.
  always_comb begin
    sum   = {1'b0, a_in} + {1'b0, b_in};
    dif   = {1'b0, a_in} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, 1'b1};
    alu_r = a_in & b_in;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_control)
      4'd0: alu_r = a_in & b_in;
      4'd1: alu_r = a_in | b_in;
      4'd2: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a_in[MSB] == b_in[MSB]) &&
                (alu_r[MSB] != a_in[MSB]);
      end
      4'd3: begin
        alu_r = dif[WIDTH-1:0];
        alu_c = dif[WIDTH];
        alu_v = (a_in[MSB] != b_in[MSB]) &&
                (alu_r[MSB] != a_in[MSB]);
      end
      4'd4:  alu_r = b_in;
      4'd5:  alu_r = ~(a_in | b_in);
      4'd6:  alu_r = a_in ^ b_in;
      4'd7:  alu_r = a_in << shamt;
      4'd8:  alu_r = a_in >> shamt;
      4'd9:  alu_r = $signed(a_in) >>> shamt;
      4'd10: alu_r = {{(WIDTH-1){1'b0}},
                      $signed(a_in) < $signed(b_in)};
      default: alu_r = a_in & b_in;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    ov_d     = ov_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (ov_q && out_ready) ov_d = 1'b0;
        if (accept) begin
          if (is_mul) begin
            state_d  = MUL;
            mcand_d  = a_in;
            mplier_d = b_in;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            res_d = alu_r;
            z_d   = (alu_r == '0);
            n_d   = alu_r[MSB];
            c_d   = alu_c;
            v_d   = alu_v;
            ov_d  = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (last_it) begin
          state_d = IDLE;
          res_d   = acc_nx;
          z_d     = (acc_nx == '0);
          n_d     = acc_nx[MSB];
          c_d     = 1'b0;
          v_d     = 1'b0;
          ov_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      ov_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      ov_q     <= ov_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and streaming checks for multicycle_alu (WIDTH=32, MUL_EN=1).
module tb_multicycle_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        zero, negative, carry, overflow;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  multicycle_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result),
    .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    in_valid    = 1'b1;
    alu_control = op;
    a_in        = a;
    b_in        = b;
    step();
    in_valid    = 1'b0;
  endtask

  // {zero, negative, carry, overflow, result}
  function automatic logic [35:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd3: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd4: r = b;
      4'd5: r = ~(a | b);
      4'd6: r = a ^ b;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: r = $signed(a) >>> b[4:0];
      4'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = a & b;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, busy, zero, negative, carry, overflow,
         alu_result} !== 38'd0)
      $display("FAIL reset_state: got %h want 0",
               {out_valid, busy, zero, negative, carry,
                overflow, alu_result});
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add();
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);
    total_cnt++;
    if ({out_valid, zero, negative, carry, overflow, alu_result}
        !== {5'b1_1010, 32'h0})
      $display("FAIL add_carry: got %h want %h",
               {out_valid, zero, negative, carry, overflow, alu_result},
               {5'b1_1010, 32'h0});
    else pass_cnt++;
    issue(4'd2, 32'h7FFF_FFFF, 32'd1);
    total_cnt++;
    if ({out_valid, zero, negative, carry, overflow, alu_result}
        !== {5'b1_0101, 32'h8000_0000})
      $display("FAIL add_ovf: got %h want %h",
               {out_valid, zero, negative, carry, overflow, alu_result},
               {5'b1_0101, 32'h8000_0000});
    else pass_cnt++;
  endtask

  task automatic test_sub_slt();
    issue(4'd3, 32'd3, 32'd5);
    total_cnt++;
    if ({out_valid, zero, negative, carry, overflow, alu_result}
        !== {5'b1_0100, 32'hFFFF_FFFE})
      $display("FAIL sub_borrow: got %h want %h",
               {out_valid, zero, negative, carry, overflow, alu_result},
               {5'b1_0100, 32'hFFFF_FFFE});
    else pass_cnt++;
    issue(4'd10, 32'd3, 32'd5);
    total_cnt++;
    if ({out_valid, zero, negative, carry, overflow, alu_result}
        !== {5'b1_0000, 32'd1})
      $display("FAIL slt: got %h want %h",
               {out_valid, zero, negative, carry, overflow, alu_result},
               {5'b1_0000, 32'd1});
    else pass_cnt++;
    issue(4'd5, 32'd0, 32'd0);
    total_cnt++;
    if ({out_valid, zero, negative, carry, overflow, alu_result}
        !== {5'b1_0100, 32'hFFFF_FFFF})
      $display("FAIL nor: got %h want %h",
               {out_valid, zero, negative, carry, overflow, alu_result},
               {5'b1_0100, 32'hFFFF_FFFF});
    else pass_cnt++;
  endtask

  task automatic test_shift();
    issue(4'd9, 32'h8000_0000, 32'h24);
    total_cnt++;
    if ({out_valid, negative, alu_result} !== {2'b11, 32'hF800_0000})
      $display("FAIL sra: got %h want %h",
               {out_valid, negative, alu_result},
               {2'b11, 32'hF800_0000});
    else pass_cnt++;
    issue(4'd8, 32'h8000_0000, 32'h24);
    total_cnt++;
    if ({out_valid, negative, alu_result} !== {2'b10, 32'h0800_0000})
      $display("FAIL srl: got %h want %h",
               {out_valid, negative, alu_result},
               {2'b10, 32'h0800_0000});
    else pass_cnt++;
    issue(4'd7, 32'd1, 32'd31);
    total_cnt++;
    if ({out_valid, negative, alu_result} !== {2'b11, 32'h8000_0000})
      $display("FAIL sll: got %h want %h",
               {out_valid, negative, alu_result},
               {2'b11, 32'h8000_0000});
    else pass_cnt++;
  endtask

  task automatic run_mul(input string nm,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp_r,
                         input logic exp_n);
    int cyc;
    int bad_rdy;
    cyc = 0;
    bad_rdy = 0;
    issue(4'd11, a, b);
    a_in = 32'hDEAD_BEEF;
    b_in = 32'h1234_5678;
    while (busy === 1'b1 && cyc < 100) begin
      if (in_ready !== 1'b0) bad_rdy++;
      cyc++;
      step();
    end
    total_cnt++;
    if (cyc !== 32)
      $display("FAIL %s_busy_cycles: got %0d want 32", nm, cyc);
    else pass_cnt++;
    total_cnt++;
    if (bad_rdy !== 0)
      $display("FAIL %s_in_ready_low: got %0d ready cycles want 0",
               nm, bad_rdy);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid, zero, negative, carry, overflow, alu_result}
        !== {1'b1, 1'b0, exp_n, 2'b00, exp_r})
      $display("FAIL %s_result: got %h want %h", nm,
               {out_valid, zero, negative, carry, overflow, alu_result},
               {1'b1, 1'b0, exp_n, 2'b00, exp_r});
    else pass_cnt++;
  endtask

  task automatic test_mul();
    run_mul("mul_small", 32'd12345, 32'd678, 32'd8369910, 1'b0);
    run_mul("mul_wrap", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    seen = 0;
    issue(4'd11, 32'd7, 32'd9);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({busy, out_valid, in_ready} !== 3'b001)
      $display("FAIL mul_reset: got %b want 001",
               {busy, out_valid, in_ready});
    else pass_cnt++;
    repeat (40) begin
      if (out_valid !== 1'b0) seen++;
      step();
    end
    total_cnt++;
    if (seen !== 0)
      $display("FAIL mul_reset_no_output: got %0d valid cycles want 0",
               seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_stall();
    out_ready = 1'b0;
    issue(4'd2, 32'd5, 32'd7);
    in_valid    = 1'b1;
    alu_control = 4'd3;
    a_in        = 32'd10;
    b_in        = 32'd3;
    repeat (5) begin
      total_cnt++;
      if ({out_valid, in_ready, zero, negative, carry, overflow,
           alu_result} !== {6'b10_0000, 32'd12})
        $display("FAIL stall_hold: got %h want %h",
                 {out_valid, in_ready, zero, negative, carry,
                  overflow, alu_result}, {6'b10_0000, 32'd12});
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, zero, negative, carry, overflow, alu_result}
        !== {5'b1_0010, 32'd7})
      $display("FAIL stall_release: got %h want %h",
               {out_valid, zero, negative, carry, overflow, alu_result},
               {5'b1_0010, 32'd7});
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL stall_no_dup: got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [35:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd11) op = 4'd2;
      a = $urandom();
      b = $urandom();
      if (i % 7 == 0) b = a;
      exp = model(op, a, b);
      in_valid    = 1'b1;
      alu_control = op;
      a_in        = a;
      b_in        = b;
      total_cnt++;
      if (in_ready !== 1'b1)
        $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({out_valid, zero, negative, carry, overflow, alu_result}
          !== {1'b1, exp})
        $display("FAIL stream[%0d] op %0d: got %h want %h", i, op,
                 {out_valid, zero, negative, carry, overflow,
                  alu_result}, {1'b1, exp});
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    a_in        = '0;
    b_in        = '0;
    alu_control = '0;
    out_ready   = 1'b1;
    test_reset();
    test_add();
    test_sub_slt();
    test_shift();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back_stall();
    test_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
